// File: rtl/vga_scene_renderer.sv
// vga_scene_renderer: 640x480 VGA raster, per-frame game-state snapshot, prioritised object drawing and goal tallies.
module vga_scene_renderer #(
  parameter int H_ACTIVE      = 640,
  parameter int H_FP          = 16,
  parameter int H_SYNC        = 96,
  parameter int H_BP          = 48,
  parameter int V_ACTIVE      = 480,
  parameter int V_FP          = 10,
  parameter int V_SYNC        = 2,
  parameter int V_BP          = 33,
  parameter int PIXEL_DIV     = 2,
  parameter int PLAYER_RADIUS = 20,
  parameter int BALL_RADIUS   = 8,
  parameter int GOAL_RADIUS   = 40,
  parameter int TEAM1_HOR_POS = 40,
  parameter int TEAM2_HOR_POS = 600
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [9:0]  team1_ver_position,
  input  logic [9:0]  team2_ver_position,
  input  logic [18:0] ball_hor_position,
  input  logic [18:0] ball_ver_position,
  input  logic        team1_score,
  input  logic        team2_score,
  input  logic [7:0]  time_left,
  output logic        hsync,
  output logic        vsync,
  output logic [3:0]  red,
  output logic [3:0]  green,
  output logic [3:0]  blue,
  output logic        frame_start,
  output logic [3:0]  team1_goals,
  output logic [3:0]  team2_goals
);
  localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
  localparam int DW = PIXEL_DIV > 1 ? $clog2(PIXEL_DIV) : 1;
  localparam logic [9:0] H_LAST = 10'(H_TOTAL - 1);
  localparam logic [9:0] V_LAST = 10'(V_TOTAL - 1);
  localparam logic [9:0] HA     = 10'(H_ACTIVE);
  localparam logic [9:0] VA     = 10'(V_ACTIVE);
  localparam logic [9:0] HS0    = 10'(H_ACTIVE + H_FP);
  localparam logic [9:0] HS1    = 10'(H_ACTIVE + H_FP + H_SYNC);
  localparam logic [9:0] VS0    = 10'(V_ACTIVE + V_FP);
  localparam logic [9:0] VS1    = 10'(V_ACTIVE + V_FP + V_SYNC);
  localparam logic [9:0] GOAL_X = 10'(H_ACTIVE - 4);
  localparam logic [9:0] MID_Y  = 10'(V_ACTIVE / 2);
  localparam logic [9:0] T1X    = 10'(TEAM1_HOR_POS);
  localparam logic [9:0] T2X    = 10'(TEAM2_HOR_POS);
  localparam logic signed [10:0] PR = 11'(PLAYER_RADIUS);
  localparam logic signed [10:0] BR = 11'(BALL_RADIUS);
  localparam logic signed [10:0] GR = 11'(GOAL_RADIUS);

  function automatic logic near(input logic [9:0] a, input logic [9:0] c, input logic signed [10:0] r);
    logic signed [10:0] d;
    d = $signed({1'b0, a}) - $signed({1'b0, c});
    return (d >= -r) && (d <= r);
  endfunction

  logic [DW-1:0] div;
  logic          tick, h_end, v_end;
  logic [9:0]    h_cnt, v_cnt;
  logic [9:0]    p1_s, p2_s, bx_s, by_s, bar_len;
  logic          bh_s;
  logic [7:0]    tl_s;
  logic          visible, ball_hit, p1_hit, p2_hit, goal_hit, bar_hit;
  logic [11:0]   rgb_n;
  logic          t1_q, t2_q;

  assign tick  = div == DW'(PIXEL_DIV - 1);
  assign h_end = h_cnt == H_LAST;
  assign v_end = v_cnt == V_LAST;

  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) div <= '0;
    else div <= tick ? '0 : div + 1'b1;

  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      h_cnt <= '0;
      v_cnt <= '0;
    end else if (tick) begin
      h_cnt <= h_end ? '0 : h_cnt + 1'b1;
      if (h_end) v_cnt <= v_end ? '0 : v_cnt + 1'b1;
    end

  // Latched on the first blanking line so the whole next frame sees one consistent state.
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      p1_s <= MID_Y;
      p2_s <= MID_Y;
      bx_s <= '0;
      by_s <= '0;
      bh_s <= 1'b1;
      tl_s <= '0;
    end else if (tick && h_cnt == '0 && v_cnt == VA) begin
      p1_s <= team1_ver_position;
      p2_s <= team2_ver_position;
      bx_s <= ball_hor_position[9:0];
      by_s <= ball_ver_position[9:0];
      bh_s <= |ball_hor_position[18:10] || |ball_ver_position[18:10];
      tl_s <= time_left;
    end

  assign bar_len  = {1'b0, tl_s, 1'b0} + {2'b00, tl_s};
  assign visible  = h_cnt < HA && v_cnt < VA;
  assign ball_hit = !bh_s && near(h_cnt, bx_s, BR) && near(v_cnt, by_s, BR);
  assign p1_hit   = near(h_cnt, T1X, PR) && near(v_cnt, p1_s, PR);
  assign p2_hit   = near(h_cnt, T2X, PR) && near(v_cnt, p2_s, PR);
  assign goal_hit = (h_cnt < 10'd4 || h_cnt >= GOAL_X) && near(v_cnt, MID_Y, GR);
  assign bar_hit  = v_cnt < 10'd8 && h_cnt < bar_len;

  always_comb
    rgb_n = !visible ? 12'h000 :
            ball_hit ? 12'hFFF :
            p1_hit   ? 12'hF00 :
            p2_hit   ? 12'h00F :
            goal_hit ? 12'hFF0 :
            bar_hit  ? 12'h0F0 : 12'h030;

  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      hsync       <= 1'b1;
      vsync       <= 1'b1;
      red         <= '0;
      green       <= '0;
      blue        <= '0;
      frame_start <= 1'b0;
    end else begin
      frame_start <= tick && h_end && v_end;
      if (tick) begin
        hsync <= !(h_cnt >= HS0 && h_cnt < HS1);
        vsync <= !(v_cnt >= VS0 && v_cnt < VS1);
        {red, green, blue} <= rgb_n;
      end
    end

  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      t1_q        <= 1'b0;
      t2_q        <= 1'b0;
      team1_goals <= '0;
      team2_goals <= '0;
    end else begin
      t1_q <= team1_score;
      t2_q <= team2_score;
      if (team1_score && !t1_q && team1_goals != 4'hF) team1_goals <= team1_goals + 1'b1;
      if (team2_score && !t2_q && team2_goals != 4'hF) team2_goals <= team2_goals + 1'b1;
    end
endmodule

// File: tb/tb_vga_scene_renderer.sv
// tb_vga_scene_renderer: shrunken-raster bench with a per-clock reference model and directed pixel checks.
module tb_vga_scene_renderer;
  localparam int HA = 64, HFP = 2, HS = 4, HBP = 2, HT = HA + HFP + HS + HBP;
  localparam int VA = 48, VFP = 2, VS = 2, VBP = 2, VT = VA + VFP + VS + VBP;
  localparam int DIV = 2, PR = 4, BR = 2, GR = 8, T1X = 4, T2X = 60;
  localparam int FR = HT * VT;
  localparam int BOUND = 2 * FR * DIV;

  logic        clk = 0, rst_n = 0;
  logic [9:0]  team1_ver_position, team2_ver_position;
  logic [18:0] ball_hor_position, ball_ver_position;
  logic        team1_score, team2_score;
  logic [7:0]  time_left;
  logic        hsync, vsync, frame_start;
  logic [3:0]  red, green, blue, team1_goals, team2_goals;

  vga_scene_renderer #(
    .H_ACTIVE(HA), .H_FP(HFP), .H_SYNC(HS), .H_BP(HBP),
    .V_ACTIVE(VA), .V_FP(VFP), .V_SYNC(VS), .V_BP(VBP),
    .PIXEL_DIV(DIV), .PLAYER_RADIUS(PR), .BALL_RADIUS(BR), .GOAL_RADIUS(GR),
    .TEAM1_HOR_POS(T1X), .TEAM2_HOR_POS(T2X)
  ) dut (
    .clk(clk), .rst_n(rst_n),
    .team1_ver_position(team1_ver_position), .team2_ver_position(team2_ver_position),
    .ball_hor_position(ball_hor_position), .ball_ver_position(ball_ver_position),
    .team1_score(team1_score), .team2_score(team2_score), .time_left(time_left),
    .hsync(hsync), .vsync(vsync), .red(red), .green(green), .blue(blue),
    .frame_start(frame_start), .team1_goals(team1_goals), .team2_goals(team2_goals)
  );

  always #5 clk = ~clk;

  int passed = 0, total = 0;

  task automatic chk(string name, int act, int exp);
    total++;
    if (act == exp) passed++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  // Model: c counts clocks since reset release; the scene is whatever the inputs were at the snapshot tick.
  int c, m_p1, m_p2, m_bx, m_by, m_tl;
  bit m_bh;
  always @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      c <= 0; m_p1 <= VA / 2; m_p2 <= VA / 2; m_bx <= 0; m_by <= 0; m_bh <= 1; m_tl <= 0;
    end else begin
      c <= c + 1;
      if (c % DIV == DIV - 1 && (c / DIV) % FR == VA * HT) begin
        m_p1 <= int'(team1_ver_position);
        m_p2 <= int'(team2_ver_position);
        m_bx <= int'(ball_hor_position) % 1024;
        m_by <= int'(ball_ver_position) % 1024;
        m_bh <= ball_hor_position >= 1024 || ball_ver_position >= 1024;
        m_tl <= int'(time_left);
      end
    end

  function automatic bit in_sq(int x, int y, int cx, int cy, int r);
    return x - cx <= r && cx - x <= r && y - cy <= r && cy - y <= r;
  endfunction

  function automatic int exp_rgb(int x, int y);
    if (x >= HA || y >= VA) return 0;
    if (!m_bh && in_sq(x, y, m_bx, m_by, BR)) return 'hFFF;
    if (in_sq(x, y, T1X, m_p1, PR)) return 'hF00;
    if (in_sq(x, y, T2X, m_p2, PR)) return 'h00F;
    if ((x < 4 || x >= HA - 4) && y - VA / 2 <= GR && VA / 2 - y <= GR) return 'hFF0;
    if (y < 8 && x < 3 * m_tl) return 'h0F0;
    return 'h030;
  endfunction

  always @(negedge clk) begin
    int q, h, v, e_rgb;
    bit e_hs, e_vs, e_fs;
    if (!rst_n || c < DIV) begin
      e_hs = 1; e_vs = 1; e_rgb = 0; e_fs = 0;
    end else begin
      q = (c / DIV - 1) % FR;
      h = q % HT;
      v = q / HT;
      e_hs = !(h >= HA + HFP && h < HA + HFP + HS);
      e_vs = !(v >= VA + VFP && v < VA + VFP + VS);
      e_rgb = exp_rgb(h, v);
      e_fs = c % DIV == 0 && (c / DIV) % FR == 0;
    end
    chk("hsync", int'(hsync), int'(e_hs));
    chk("vsync", int'(vsync), int'(e_vs));
    chk("rgb", int'({red, green, blue}), e_rgb);
    chk("frame_start", int'(frame_start), int'(e_fs));
  end

  // f < 0 waits for the pixel in any frame.
  task automatic wait_pix(int f, int x, int y);
    int t, i;
    t = (f < 0 ? 0 : f * FR) + y * HT + x;
    i = 0;
    while (!(c >= DIV && (f < 0 ? (c / DIV - 1) % FR : c / DIV - 1) == t) && i < BOUND) begin
      @(negedge clk);
      i++;
    end
    if (i >= BOUND) begin
      total++;
      $display("FAIL wait_pix f%0d (%0d,%0d): pixel never reached", f, x, y);
    end
  endtask

  task automatic px(string name, int f, int x, int y, int exp);
    wait_pix(f, x, y);
    chk(name, int'({red, green, blue}), exp);
  endtask

  initial begin
    int hs_low, vs_low, fs_cnt, i;
    team1_ver_position = 24; team2_ver_position = 24;
    ball_hor_position = 32; ball_ver_position = 24;
    time_left = 10; team1_score = 0; team2_score = 0;
    repeat (3) @(negedge clk);
    chk("rst_hsync", int'(hsync), 1);
    chk("rst_vsync", int'(vsync), 1);
    chk("rst_rgb", int'({red, green, blue}), 0);
    chk("rst_goals", int'({team1_goals, team2_goals}), 0);
    #2 rst_n = 1;
    px("f0_no_bar", 0, 5, 3, 'h030);
    px("f0_p1_reset", 0, 4, 24, 'hF00);
    px("f0_ball_hidden", 0, 32, 24, 'h030);
    px("f1_bar_end", 1, 29, 3, 'h0F0);
    px("f1_bar_past", 1, 30, 3, 'h030);
    px("f1_bg", 1, 10, 10, 'h030);
    px("f1_goal_above", 1, 63, 15, 'h030);
    px("f1_goal_top", 1, 63, 16, 'hFF0);
    px("f1_p1", 1, 4, 24, 'hF00);
    px("f1_ball", 1, 32, 24, 'hFFF);
    px("f1_p2", 1, 60, 24, 'h00F);
    px("f1_goal_left", 1, 0, 30, 'hFF0);
    px("f1_goal_below", 1, 0, 33, 'h030);
    wait_pix(1, 0, 35);
    team1_ver_position = 40;
    ball_hor_position = (1 << 10) | 5;
    time_left = 0;
    px("f1_p1_unchanged", 1, 4, 40, 'h030);
    px("f2_no_bar", 2, 0, 3, 'h030);
    px("f2_ball_hidden", 2, 5, 24, 'h030);
    px("f2_p1_moved", 2, 4, 40, 'hF00);
    ball_hor_position = 4; ball_ver_position = 40;
    px("f3_ball_over_p1", 3, 4, 40, 'hFFF);
    px("f3_p1_edge", 3, 4, 44, 'hF00);
    px("f3_p1_past", 3, 4, 45, 'h030);
    i = 0;
    while (!frame_start && i < BOUND) begin @(negedge clk); i++; end
    chk("fs_seen", int'(frame_start), 1);
    hs_low = 0; vs_low = 0; fs_cnt = 0;
    for (int k = 0; k < FR * DIV; k++) begin
      @(negedge clk);
      hs_low += int'(!hsync);
      vs_low += int'(!vsync);
      fs_cnt += int'(frame_start);
    end
    chk("hsync_low_clks", hs_low, VT * HS * DIV);
    chk("vsync_low_clks", vs_low, VS * HT * DIV);
    chk("fs_per_frame", fs_cnt, 1);
    chk("fs_period", int'(frame_start), 1);
    for (int k = 0; k < 17; k++) begin
      team1_score = 1; team2_score = k < 2;
      repeat (2) @(negedge clk);
      team1_score = 0; team2_score = 0;
      repeat (2) @(negedge clk);
      if (k == 0) chk("goal_first", int'(team1_goals), 1);
    end
    chk("team1_sat", int'(team1_goals), 15);
    chk("team2_goals", int'(team2_goals), 2);
    px("pre_reset_p2", -1, 60, 24, 'h00F);
    #2 rst_n = 0;
    #1;
    chk("mid_rst_rgb", int'({red, green, blue}), 0);
    chk("mid_rst_sync", int'({hsync, vsync}), 3);
    chk("mid_rst_goals", int'({team1_goals, team2_goals}), 0);
    repeat (4) @(negedge clk);
    #2 rst_n = 1;
    px("post_rst_p1", 0, 4, 24, 'hF00);
    px("post_rst_old_pos", 0, 4, 40, 'h030);
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
